regs_if_arbiter: RTL and testbench
==================================

Name: regs_if_arbiter

Overview:
N-master arbiter that shares one register-file slave port among several register-interface masters, such as the processor, the connection monitor and debug/DMA agents.
Grants are round-robin and each grant is held for one complete transaction, from strobe until the slave responds.
Responses are routed only to the granted master. A per-transaction timeout keeps a silent slave from locking the bus.

Parameters:
N_MASTERS, 2, number of master ports (≥2)
ADDR_W, 8, register address width
DATA_W, 32, register data width
TIMEOUT, 255, max cycles waiting for slave response before error (≥1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  reset; one clock, reset asynchronous active-low
m_write_en  in  N_MASTERS  per-master write request (level, held until done/error)
m_read_en  in  N_MASTERS  per-master read request (level, held until ready/error)
m_addr  in  N_MASTERS*ADDR_W  packed per-master address, master i at [i*ADDR_W +: ADDR_W]
m_write_data  in  N_MASTERS*DATA_W  packed per-master write data
m_read_data  out  DATA_W  registered read data, valid with m_data_ready
m_data_ready  out  N_MASTERS  one-cycle read-complete pulse, one-hot to granted master
m_write_done  out  N_MASTERS  one-cycle write-complete pulse, one-hot
m_error  out  N_MASTERS  one-cycle timeout pulse, coincident with done/ready pulse
s_write_en  out  1  slave write strobe, one cycle
s_read_en  out  1  slave read strobe, one cycle
s_addr  out  ADDR_W  slave address, held ISSUE..WAIT
s_write_data  out  DATA_W  slave write data, held ISSUE..WAIT
s_read_data  in  DATA_W  slave read data, sampled with s_data_ready
s_data_ready  in  1  slave read-complete pulse
s_write_done  in  1  slave write-complete pulse
grant_id  out  $clog2(N_MASTERS)  index of current owner, valid while busy
busy  out  1  high in ISSUE/WAIT/RELEASE

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE, round-robin pointer to 0, timeout counter to 0.
  - All outputs go to 0, including m_read_data, s_addr, s_write_data and grant_id.
- A master requests when m_write_en[i]|m_read_en[i]. If both are high, the write wins and the read is ignored for that transaction.
- FSM states: IDLE, ISSUE, WAIT, RELEASE.
  - IDLE: if any request is present, pick the first requester at or after the pointer (wrapping modulo N_MASTERS). Latch grant_id, op, addr and data, then go to ISSUE.
  - ISSUE: assert s_write_en or s_read_en for exactly one cycle, then go to WAIT with the counter cleared.
  - WAIT: on s_write_done or s_data_ready (matching op), register the pulse to the granted master next cycle. For reads, m_read_data <= s_read_data in the same edge. Then go to RELEASE.
    - If the counter reaches TIMEOUT-1 with no response: pulse m_error[g] together with m_write_done[g] or m_data_ready[g]; m_read_data=0. Go to RELEASE.
    - A response in the timeout cycle takes priority; m_error stays 0.
    - A response of the wrong type (e.g. write_done during a read) is ignored.
  - RELEASE: one cycle. pointer <= grant_id+1 (wrap at N_MASTERS-1 -> 0), then IDLE. This gap gives the master one cycle to drop its request after seeing done.
- Latency: request seen at edge 0, strobe in cycle 1, slave response in cycle k≥2, master pulse in cycle k+1. Back-to-back minimum is 4 cycles per transaction.
- Slave responses in IDLE, ISSUE or RELEASE are ignored.
- A master dropping its request mid-transaction has no effect; the transaction completes and the pulse is still issued.
- Requests change only at IDLE sampling, so no starvation: each waiting master is served within N_MASTERS grants.
- Reset mid-transaction aborts it. No pulse is issued and late slave responses are ignored in IDLE.

Decomposition:
- Package regs_arb_pkg: state enum arb_state_t {IDLE, ISSUE, WAIT, RELEASE}; op enum {OP_READ, OP_WRITE}; helper function for clog2-safe index width.
- Sub-module rr_priority_arbiter: combinational, with inputs req[N] and pointer, and outputs grant_valid and grant_idx. The pointer register stays in the parent.

Test Plan:
- Single read, master 0, addr 0x10, slave ready 3 cycles after strobe with 0xDEADBEEF -> s_read_en 1 cycle, m_data_ready[0] pulse, m_read_data=0xDEADBEEF, m_data_ready[1]=0.
- N=3, all request writes simultaneously from reset -> grants in order 0,1,2. Then master 0 re-requests -> grant 0 after 2, pointer wraps.
- Master 1 write with slave silent, TIMEOUT=8 -> m_error[1] and m_write_done[1] pulse exactly 9 cycles after strobe, busy drops 1 cycle later.
- Both m_read_en[0] and m_write_en[0] high, data 0x55 -> s_write_en only, s_write_data=0x55.
- Spurious s_data_ready in IDLE and a wrong-type s_write_done during a read -> no master pulses; the read still completes on the later s_data_ready.
- rst_n low in WAIT, slave responds during reset and 1 cycle after -> all outputs 0, no m_* pulse, next grant starts from master 0.

Source files
------------

// File: rtl/regs_if_arbiter_pkg.sv
// Shared types for the register-interface arbiter: FSM states, operation
// kind and an index-width helper that stays legal for single-entry ranges.
package regs_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} arb_state_t;
    typedef enum logic {OP_READ, OP_WRITE} arb_op_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regs_if_arbiter_if.sv
// Register bus between N requesting masters, the arbiter and the shared slave.
// The slave modport is the arbiter's view; master is the environment's view.
interface regs_if_arbiter_if #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32
);
    logic [N_MASTERS-1:0]        m_write_en;
    logic [N_MASTERS-1:0]        m_read_en;
    logic [N_MASTERS*ADDR_W-1:0] m_addr;
    logic [N_MASTERS*DATA_W-1:0] m_write_data;
    logic [DATA_W-1:0]           m_read_data;
    logic [N_MASTERS-1:0]        m_data_ready;
    logic [N_MASTERS-1:0]        m_write_done;
    logic [N_MASTERS-1:0]        m_error;

    logic                        s_write_en;
    logic                        s_read_en;
    logic [ADDR_W-1:0]           s_addr;
    logic [DATA_W-1:0]           s_write_data;
    logic [DATA_W-1:0]           s_read_data;
    logic                        s_data_ready;
    logic                        s_write_done;

    modport slave (
        input  m_write_en, m_read_en, m_addr, m_write_data,
        output m_read_data, m_data_ready, m_write_done, m_error,
        output s_write_en, s_read_en, s_addr, s_write_data,
        input  s_read_data, s_data_ready, s_write_done
    );

    modport master (
        output m_write_en, m_read_en, m_addr, m_write_data,
        input  m_read_data, m_data_ready, m_write_done, m_error,
        input  s_write_en, s_read_en, s_addr, s_write_data,
        output s_read_data, s_data_ready, s_write_done
    );

endinterface

// File: rtl/regs_if_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_priority_arbiter
    import regs_arb_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        sum         = '0;
        idx         = '0;
        for (int i = N - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(N))
                sum = sum - (IDX_W+1)'(N);
            idx = sum[IDX_W-1:0];
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/regs_if_arbiter.sv
// Round-robin arbiter sharing one register slave among N masters; a grant
// covers a whole transaction and a timeout bounds the wait for the slave.
module regs_if_arbiter
    import regs_arb_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    regs_if_arbiter_if.slave             bus,
    output logic [$clog2(N_MASTERS)-1:0] grant_id,
    output logic                         busy
);

    localparam int IDX_W = idx_w(N_MASTERS);
    localparam int CNT_W = idx_w(TIMEOUT);

    arb_state_t             state, state_nxt;
    arb_op_t                op;
    logic [IDX_W-1:0]       ptr, grant, arb_idx;
    logic                   arb_valid;
    logic [CNT_W-1:0]       cnt;
    logic [N_MASTERS-1:0]   req;
    logic                   resp, timed_out;
    logic [ADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]      wdata_q, rdata_q;
    logic [N_MASTERS-1:0]   ready_q, done_q, err_q;
    logic                   wr_stb, rd_stb;

    assign req = bus.m_write_en | bus.m_read_en;

    rr_priority_arbiter #(.N(N_MASTERS), .IDX_W(IDX_W)) u_rr (
        .req         (req),
        .ptr         (ptr),
        .grant_valid (arb_valid),
        .grant_idx   (arb_idx)
    );

    // Only the response matching the latched op counts; the other is ignored.
    assign resp      = (op == OP_WRITE) ? bus.s_write_done : bus.s_data_ready;
    assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (resp || timed_out) state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_stb = (state == ISSUE) && (op == OP_WRITE);
        rd_stb = (state == ISSUE) && (op == OP_READ);
        busy   = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            grant   <= '0;
            op      <= OP_READ;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
        end else begin
            ready_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            case (state)
                IDLE: if (arb_valid) begin
                    grant   <= arb_idx;
                    op      <= bus.m_write_en[arb_idx] ? OP_WRITE : OP_READ;
                    addr_q  <= bus.m_addr[arb_idx*ADDR_W +: ADDR_W];
                    wdata_q <= bus.m_write_data[arb_idx*DATA_W +: DATA_W];
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    if (resp || timed_out) begin
                        if (op == OP_WRITE) begin
                            done_q[grant] <= 1'b1;
                        end else begin
                            ready_q[grant] <= 1'b1;
                            rdata_q        <= resp ? bus.s_read_data : '0;
                        end
                        err_q[grant] <= !resp;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: ptr <= (grant == IDX_W'(N_MASTERS - 1)) ? '0 : grant + 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.s_write_en   = wr_stb;
    assign bus.s_read_en    = rd_stb;
    assign bus.s_addr       = addr_q;
    assign bus.s_write_data = wdata_q;
    assign bus.m_read_data  = rdata_q;
    assign bus.m_data_ready = ready_q;
    assign bus.m_write_done = done_q;
    assign bus.m_error      = err_q;
    assign grant_id         = grant;

endmodule

// File: tb/tb_regs_if_arbiter.sv
// Directed bench for regs_if_arbiter with three masters and a short timeout.
module tb_regs_if_arbiter;

    localparam int N  = 3;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 8;

    logic         clk;
    logic         rst_n;
    logic [1:0]   grant_id;
    logic         busy;
    int           checks;
    int           passes;

    regs_if_arbiter_if #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    regs_if_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .grant_id (grant_id),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          m;
        bit          wr;
        bit          rd;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          delay;   // response cycle after strobe, 0 = silent slave
        int          wrong;   // cycle of a wrong-type response, 0 = none
        logic [31:0] rdata;
        bit          err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_req(input int g, input bit wr, input bit rd,
                           input logic [7:0] addr, input logic [31:0] data);
        bus.m_write_en[g]          = wr;
        bus.m_read_en[g]           = rd;
        bus.m_addr[g*AW +: AW]     = addr;
        bus.m_write_data[g*DW +: DW] = data;
    endtask

    task automatic clr_req(input int g);
        bus.m_write_en[g] = 1'b0;
        bus.m_read_en[g]  = 1'b0;
    endtask

    // Wait for the strobe, check it, play the slave, then check the master pulse.
    task automatic serve(input int g, input bit wr, input logic [7:0] addr,
                         input logic [31:0] wdata, input int delay, input int wrong,
                         input logic [31:0] rdata, input bit exp_err,
                         input logic [31:0] exp_rd);
        bit          seen;
        int          exp_c, lim, first, npulse;
        logic [2:0]  dr, wd, er, oh;
        logic [31:0] rd;
        seen = 0; first = 0; npulse = 0;
        dr = '0; wd = '0; er = '0; rd = '0;
        oh = 3'b001 << g;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (bus.s_write_en || bus.s_read_en) seen = 1;
        end
        chk("strobe seen", 64'(seen), 64'd1);
        if (!seen) begin
            clr_req(g);
            return;
        end
        chk("strobe type", {bus.s_write_en, bus.s_read_en}, wr ? 2'b10 : 2'b01);
        chk("grant_id", grant_id, g);
        chk("s_addr", bus.s_addr, addr);
        if (wr) chk("s_write_data", bus.s_write_data, wdata);
        chk("busy in issue", busy, 1);
        exp_c = (delay == 0 || delay > TO) ? TO + 1 : delay + 1;
        lim = exp_c;
        if (delay > lim) lim = delay;
        if (wrong > lim) lim = wrong;
        lim++;
        for (int c = 1; c <= lim; c++) begin
            @(negedge clk);
            if (c == 1) chk("strobe width", {bus.s_write_en, bus.s_read_en}, 2'b00);
            if (|(bus.m_data_ready | bus.m_write_done | bus.m_error)) begin
                npulse++;
                if (first == 0) begin
                    first = c;
                    dr = bus.m_data_ready;
                    wd = bus.m_write_done;
                    er = bus.m_error;
                    rd = bus.m_read_data;
                    clr_req(g);
                end
            end
            if (c == exp_c + 1) chk("busy after release", busy, 0);
            bus.s_data_ready = 1'b0;
            bus.s_write_done = 1'b0;
            if (c == delay) begin
                if (wr) bus.s_write_done = 1'b1;
                else begin
                    bus.s_data_ready = 1'b1;
                    bus.s_read_data  = rdata;
                end
            end
            if (c == wrong) begin
                if (wr) bus.s_data_ready = 1'b1;
                else    bus.s_write_done = 1'b1;
            end
        end
        clr_req(g);
        chk("pulse cycle", first, exp_c);
        chk("pulse count", npulse, 1);
        chk("m_data_ready", dr, wr ? 3'b000 : oh);
        chk("m_write_done", wd, wr ? oh : 3'b000);
        chk("m_error", er, exp_err ? oh : 3'b000);
        if (!wr) chk("m_read_data", rd, exp_rd);
    endtask

    initial begin
        bit seen;
        checks = 0;
        passes = 0;
        rst_n  = 1'b0;
        bus.m_write_en   = '0;
        bus.m_read_en    = '0;
        bus.m_addr       = '0;
        bus.m_write_data = '0;
        bus.s_read_data  = '0;
        bus.s_data_ready = 1'b0;
        bus.s_write_done = 1'b0;

        vecs[0] = '{0, 1'b0, 1'b1, 8'h10, 32'h0,        3, 0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
        vecs[1] = '{1, 1'b1, 1'b0, 8'h20, 32'h12345678, 1, 0, 32'h0,        1'b0, 32'h0};
        vecs[2] = '{1, 1'b1, 1'b0, 8'h21, 32'hCAFEF00D, 0, 0, 32'h0,        1'b1, 32'h0};
        vecs[3] = '{0, 1'b1, 1'b1, 8'h30, 32'h55,       2, 0, 32'h0,        1'b0, 32'h0};
        vecs[4] = '{2, 1'b0, 1'b1, 8'h40, 32'h0,        0, 0, 32'h0,        1'b1, 32'h0};
        vecs[5] = '{1, 1'b0, 1'b1, 8'h50, 32'h0,        8, 0, 32'h0BADF00D, 1'b0, 32'h0BADF00D};
        vecs[6] = '{2, 1'b0, 1'b1, 8'h60, 32'h0,        9, 0, 32'h11111111, 1'b1, 32'h0};
        vecs[7] = '{0, 1'b0, 1'b1, 8'h70, 32'h0,        4, 2, 32'h600DCAFE, 1'b0, 32'h600DCAFE};
        vecs[8] = '{2, 1'b1, 1'b0, 8'hFF, 32'hFFFFFFFF, 1, 0, 32'h0,        1'b0, 32'h0};

        repeat (3) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset grant_id", grant_id, 0);
        chk("reset strobes", {bus.s_write_en, bus.s_read_en}, 2'b00);
        chk("reset s_addr/s_write_data", {bus.s_addr, bus.s_write_data}, 40'h0);
        chk("reset pulses", {bus.m_data_ready, bus.m_write_done, bus.m_error}, 9'h0);
        chk("reset m_read_data", bus.m_read_data, 32'h0);
        rst_n = 1'b1;

        // All three masters write at once: served 0,1,2, then the pointer wraps.
        set_req(0, 1'b1, 1'b0, 8'h01, 32'hA0);
        set_req(1, 1'b1, 1'b0, 8'h02, 32'hA1);
        set_req(2, 1'b1, 1'b0, 8'h03, 32'hA2);
        serve(0, 1'b1, 8'h01, 32'hA0, 1, 0, 32'h0, 1'b0, 32'h0);
        serve(1, 1'b1, 8'h02, 32'hA1, 2, 0, 32'h0, 1'b0, 32'h0);
        serve(2, 1'b1, 8'h03, 32'hA2, 1, 0, 32'h0, 1'b0, 32'h0);
        set_req(0, 1'b1, 1'b0, 8'h04, 32'hB0);
        set_req(1, 1'b1, 1'b0, 8'h05, 32'hB1);
        serve(0, 1'b1, 8'h04, 32'hB0, 1, 0, 32'h0, 1'b0, 32'h0);
        serve(1, 1'b1, 8'h05, 32'hB1, 1, 0, 32'h0, 1'b0, 32'h0);

        for (int v = 0; v < 9; v++) begin
            set_req(vecs[v].m, vecs[v].wr, vecs[v].rd, vecs[v].addr, vecs[v].wdata);
            serve(vecs[v].m, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].delay,
                  vecs[v].wrong, vecs[v].rdata, vecs[v].err, vecs[v].exp_rd);
        end

        // Slave responses while idle must not reach any master.
        bus.s_data_ready = 1'b1;
        bus.s_write_done = 1'b1;
        @(negedge clk);
        bus.s_data_ready = 1'b0;
        bus.s_write_done = 1'b0;
        chk("idle spurious pulses", {bus.m_data_ready, bus.m_write_done, bus.m_error}, 9'h0);
        chk("idle spurious busy", busy, 0);
        @(negedge clk);
        chk("idle spurious pulses later", {bus.m_data_ready, bus.m_write_done, bus.m_error}, 9'h0);

        // Leave the pointer at 2, then reset during WAIT of a master 1 read.
        set_req(1, 1'b1, 1'b0, 8'h08, 32'hC1);
        serve(1, 1'b1, 8'h08, 32'hC1, 1, 0, 32'h0, 1'b0, 32'h0);
        set_req(1, 1'b0, 1'b1, 8'h44, 32'h0);
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (bus.s_read_en) seen = 1;
        end
        chk("reset-test strobe seen", 64'(seen), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        bus.s_data_ready = 1'b1;
        bus.s_read_data  = 32'hCAFE0001;
        clr_req(1);
        @(negedge clk);
        chk("mid reset busy", busy, 0);
        chk("mid reset grant_id", grant_id, 0);
        chk("mid reset slave side", {bus.s_write_en, bus.s_read_en, bus.s_addr, bus.s_write_data}, 42'h0);
        chk("mid reset master side", {bus.m_data_ready, bus.m_write_done, bus.m_error, bus.m_read_data}, 41'h0);
        rst_n = 1'b1;
        @(negedge clk);
        bus.s_data_ready = 1'b0;
        chk("post reset no pulse", {bus.m_data_ready, bus.m_write_done, bus.m_error}, 9'h0);
        chk("post reset idle", busy, 0);
        @(negedge clk);
        chk("post reset no pulse later", {bus.m_data_ready, bus.m_write_done, bus.m_error, bus.m_read_data}, 41'h0);
        set_req(1, 1'b1, 1'b0, 8'h61, 32'h61);
        set_req(2, 1'b1, 1'b0, 8'h62, 32'h62);
        serve(1, 1'b1, 8'h61, 32'h61, 1, 0, 32'h0, 1'b0, 32'h0);
        serve(2, 1'b1, 8'h62, 32'h62, 1, 0, 32'h0, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
